stopwatch_bcd_lap: RTL

- Parametrised stopwatch that counts directly in packed BCD at a configurable sub-second resolution. No binary-to-BCD converter stage.
- Adds a clear input, lap/split hold, saturation flag and decimal-point placement.
- Sits between the debounced button pulse sources and the seven-segment display driver.
- Drives the same display / digit_enable / dp_enable contract as the existing stopwatch, generalised to DIGITS digits.

---
 rtl/stopwatch_bcd_lap.sv | 127 ++++++++++++
 1 files changed

// File: rtl/stopwatch_bcd_lap.sv
// BCD stopwatch with clear, lap hold, saturation and a fixed decimal-point mask.
// Define STOPWATCH_MMSS_EN to get minutes:seconds format (tens-of-seconds digit wraps at 5).

module stopwatch_bcd_digit #(
  parameter logic [3:0] LIMIT = 4'd9
) (
  input  logic [3:0] d,
  input  logic       carry_in,
  output logic [3:0] q,
  output logic       carry_out,
  output logic       q_at_limit
);
  always_comb begin
    carry_out = carry_in && (d == LIMIT);
    if (!carry_in)        q = d;
    else if (d == LIMIT)  q = 4'd0;
    else                  q = d + 4'd1;
    q_at_limit = (q == LIMIT);
  end
endmodule

module stopwatch_bcd_lap #(
  parameter int FREQ_HZ     = 100000000,
  parameter int FRAC_DIGITS = 2,
  parameter int DIGITS      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  clear,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   display,
  output logic [DIGITS-1:0]     digit_enable,
  output logic [DIGITS-1:0]     dp_enable,
  output logic                  running,
  output logic                  lap_active,
  output logic                  saturated
);
`ifdef STOPWATCH_MMSS_EN
  localparam bit MMSS = 1'b1;
`else
  localparam bit MMSS = 1'b0;
`endif
  localparam int PRESCALE = FREQ_HZ / (10 ** FRAC_DIGITS);
  localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam int TENS     = FRAC_DIGITS + 1;
  localparam int LO       = !MMSS ? FRAC_DIGITS : ((TENS < DIGITS) ? TENS : DIGITS - 1);

  function automatic logic [DIGITS-1:0] dp_pattern();
    logic [DIGITS-1:0] m;
    m = '0;
    if (FRAC_DIGITS > 0) m[FRAC_DIGITS] = 1'b1;
    if (MMSS && (FRAC_DIGITS + 2 < DIGITS)) m[FRAC_DIGITS+2] = 1'b1;
    return m;
  endfunction

  logic [DIGITS-1:0][3:0] count, lap_reg, count_inc, shown;
  logic [DIGITS:0]        carry;
  logic [DIGITS-1:0]      inc_lim;
  logic [PW-1:0]          prescaler;
  logic                   tick, at_max;

  // Ripple carry resolves in one cycle; carry out of the top digit means every digit is at its limit.
  assign carry[0] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    stopwatch_bcd_digit #(.LIMIT((MMSS && g == TENS) ? 4'd5 : 4'd9)) u_digit (
      .d          (count[g]),
      .carry_in   (carry[g]),
      .q          (count_inc[g]),
      .carry_out  (carry[g+1]),
      .q_at_limit (inc_lim[g])
    );
  end

  assign at_max    = carry[DIGITS];
  assign tick      = running && (prescaler == PMAX);
  assign shown     = lap_active ? lap_reg : count;
  assign display   = shown;
  assign dp_enable = dp_pattern();

  always_comb begin
    int top;
    top = LO;
    for (int i = 0; i < DIGITS; i++)
      if (shown[i] != 4'd0 && i > top) top = i;
    for (int i = 0; i < DIGITS; i++)
      digit_enable[i] = (i <= top);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      lap_reg    <= '0;
      prescaler  <= '0;
      running    <= 1'b0;
      lap_active <= 1'b0;
      saturated  <= 1'b0;
    end else if (clear && !running) begin
      // clear while paused also swallows a same-cycle start
      count      <= '0;
      prescaler  <= '0;
      saturated  <= 1'b0;
      lap_active <= 1'b0;
    end else begin
      if (running) begin
        if (tick) begin
          prescaler <= '0;
          if (!at_max) begin
            count     <= count_inc;
            saturated <= &inc_lim;
          end
        end else begin
          prescaler <= prescaler + 1'b1;
        end
      end
      if (start) running <= !running;
      if (lap) begin
        if (lap_active) lap_active <= 1'b0;
        else if (running) begin
          lap_reg    <= count;
          lap_active <= 1'b1;
        end
      end
    end
  end
endmodule
